board_renderer: RTL and testbench



---
 rtl/board_renderer.sv | 192 +++++++++++++++++++
 tb/tb_board_renderer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_renderer.sv
// board_renderer: rasterises the 10x20 Tetris board plus the falling tetromino
// into single-pixel writes for a 160x120 VGA adapter, one board row at a time.
module board_renderer #(
    parameter int         ORIGIN_X     = 60,
    parameter int         ORIGIN_Y     = 20,
    parameter logic [2:0] FILL_COLOUR  = 3'b111,
    parameter logic [2:0] EMPTY_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    output logic [4:0] row_addr,
    input  logic [9:0] row_data,
    input  logic [3:0] block1_x,
    input  logic [3:0] block2_x,
    input  logic [3:0] block3_x,
    input  logic [3:0] block4_x,
    input  logic [4:0] block1_y,
    input  logic [4:0] block2_y,
    input  logic [4:0] block3_y,
    input  logic [4:0] block4_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] OX       = 8'(ORIGIN_X);
    localparam logic [6:0] OY       = 7'(ORIGIN_Y);
    localparam logic [7:0] LAST_PIX = 8'd159;
    localparam logic [4:0] TOP_ROW  = 5'd19;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_DRAW,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] row_q, row_d;
    logic [7:0] pix_q, pix_d;
    logic [9:0] rbuf_q, rbuf_d;
    logic [3:0] bx_q [4];
    logic [3:0] bx_d [4];
    logic [4:0] by_q [4];
    logic [4:0] by_d [4];
    logic [3:0] bx_in [4];
    logic [4:0] by_in [4];

    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [9:0]  overlay;
    logic [39:0] hit;

    assign bx_in[0] = block1_x;
    assign bx_in[1] = block2_x;
    assign bx_in[2] = block3_x;
    assign bx_in[3] = block4_x;
    assign by_in[0] = block1_y;
    assign by_in[1] = block2_y;
    assign by_in[2] = block3_y;
    assign by_in[3] = block4_y;

    // A snapshotted block lands on column gi of the current row; spawn rows
    // (y > 19) and off-board columns (x > 9) can never match.
    genvar gi, gk;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_col
            for (gk = 0; gk < 4; gk++) begin : g_blk
                assign hit[gi*4 + gk] = (by_q[gk] == row_q) && (by_q[gk] <= TOP_ROW)
                                        && (bx_q[gk] == 4'(gi));
            end
            assign overlay[gi] = |hit[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            pix_q    <= '0;
            rbuf_q   <= '0;
            vga_x_q  <= '0;
            vga_y_q  <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                bx_q[k] <= '0;
                by_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            pix_q    <= pix_d;
            rbuf_q   <= rbuf_d;
            vga_x_q  <= vga_x_d;
            vga_y_q  <= vga_y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            for (int k = 0; k < 4; k++) begin
                bx_q[k] <= bx_d[k];
                by_q[k] <= by_d[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        pix_d   = pix_q;
        rbuf_d  = rbuf_q;
        plot_d  = plot_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bx_d[k] = bx_q[k];
            by_d[k] = by_q[k];
        end
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int k = 0; k < 4; k++) begin
                        bx_d[k] = bx_in[k];
                        by_d[k] = by_in[k];
                    end
                    row_d   = TOP_ROW;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                rbuf_d  = row_data | overlay;
                pix_d   = '0;
                plot_d  = 1'b1;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (pix_q == LAST_PIX) begin
                    plot_d = 1'b0;
                    if (row_q == 5'd0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q - 5'd1;
                        state_d = S_FETCH;
                    end
                end else begin
                    pix_d = pix_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel index = {cell column, pixel row, pixel column}; coordinates are
    // registered together with plot so the adapter sees a consistent write.
    always_comb begin
        vga_x_d  = vga_x_q;
        vga_y_d  = vga_y_q;
        colour_d = colour_q;
        if (plot_d) begin
            vga_x_d  = OX + {2'b00, pix_d[7:4], pix_d[1:0]};
            vga_y_d  = OY + {TOP_ROW - row_d, pix_d[3:2]};
            colour_d = rbuf_d[pix_d[7:4]] ? FILL_COLOUR : EMPTY_COLOUR;
        end
    end

    assign row_addr   = row_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = colour_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_board_renderer.sv
// Bench for board_renderer: builds the expected pixel stream of every frame
// from the board image and block snapshot, then checks the DUT cycle by cycle.
`timescale 1ns/1ps
module tb_board_renderer;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic       start  = 1'b0;
    logic [4:0] row_addr;
    logic [9:0] row_data = '0;
    logic [3:0] bx [4];
    logic [4:0] by [4];
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot, busy, done;

    logic [9:0] board_mem [32];
    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;
    pix_t expq[$];
    int   model_fill;

    board_renderer dut (
        .clock(clock), .resetn(resetn), .start(start),
        .row_addr(row_addr), .row_data(row_data),
        .block1_x(bx[0]), .block2_x(bx[1]), .block3_x(bx[2]), .block4_x(bx[3]),
        .block1_y(by[0]), .block2_y(by[1]), .block3_y(by[2]), .block4_y(by[3]),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Board RAM with a one-cycle registered read
    always @(posedge clock) row_data <= board_mem[row_addr];

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Expected stream: rows 19..0, each scanned cell column, pixel row, pixel column
    task automatic build_model();
        int sx[4], sy[4];
        bit occ;
        expq.delete();
        model_fill = 0;
        for (int k = 0; k < 4; k++) begin
            sx[k] = int'(bx[k]);
            sy[k] = int'(by[k]);
        end
        for (int r = 19; r >= 0; r--) begin
            for (int c = 0; c < 10; c++) begin
                occ = board_mem[r][c];
                for (int k = 0; k < 4; k++)
                    if (sy[k] == r && sx[k] == c) occ = 1'b1;
                for (int pr = 0; pr < 4; pr++)
                    for (int pc = 0; pc < 4; pc++) begin
                        expq.push_back('{60 + 4*c + pc, 20 + (19 - r)*4 + pr, occ ? 7 : 0});
                        if (occ) model_fill++;
                    end
            end
        end
    endtask

    task automatic run_frame(input bit pulse, input int restart_at, input int newblk_at,
                             input int abort_at, input bit chain,
                             output int plots, output int fills, output int dones,
                             output int xmin, output int xmax, output int ymin, output int ymax);
        pix_t e;
        bit   exp_busy, exp_done, exp_plot;
        int   exp_row;
        if (pulse) begin
            @(negedge clock);
            start = 1'b1;
        end
        build_model();
        plots = 0; fills = 0; dones = 0;
        xmin = 999; xmax = -1; ymin = 999; ymax = -1;
        for (int cyc = 1; cyc <= 3242; cyc++) begin
            @(negedge clock);
            exp_busy = (cyc <= 3240);
            exp_done = (cyc == 3241);
            exp_plot = (cyc <= 3240) && (((cyc - 1) % 162) >= 2);
            exp_row  = (cyc <= 3240) ? 19 - (cyc - 1) / 162 : 0;
            check("busy", int'(busy), int'(exp_busy));
            check("done", int'(done), int'(exp_done));
            check("plot", int'(plot), int'(exp_plot));
            check("row_addr", int'(row_addr), exp_row);
            if (exp_plot) begin
                if (expq.size() == 0) begin
                    check("model_underrun", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("vga_x", int'(vga_x), e.x);
                    check("vga_y", int'(vga_y), e.y);
                    check("vga_colour", int'(vga_colour), e.c);
                end
            end
            if (plot) begin
                plots++;
                if (vga_colour == 3'b111) begin
                    fills++;
                    if (int'(vga_x) < xmin) xmin = int'(vga_x);
                    if (int'(vga_x) > xmax) xmax = int'(vga_x);
                    if (int'(vga_y) < ymin) ymin = int'(vga_y);
                    if (int'(vga_y) > ymax) ymax = int'(vga_y);
                end
            end
            if (done) dones++;
            if (cyc == abort_at) begin
                resetn = 1'b0;
                #1;
                check("abort_plot", int'(plot), 0);
                check("abort_busy", int'(busy), 0);
                check("abort_vga_x", int'(vga_x), 0);
                check("abort_done", int'(done), 0);
                check("abort_row_addr", int'(row_addr), 0);
                break;
            end
            if (cyc == 1) start = 1'b0;
            if (cyc == restart_at) start = 1'b1;
            if (cyc == restart_at + 1) start = 1'b0;
            if (cyc == newblk_at)
                for (int k = 0; k < 4; k++) begin
                    bx[k] = 4'($urandom_range(0, 9));
                    by[k] = 5'($urandom_range(0, 19));
                end
            if (cyc == 3241) start = 1'b1;
            if (cyc == 3242) start = chain;
        end
    endtask

    task automatic clear_setup();
        for (int r = 0; r < 32; r++) board_mem[r] = '0;
        for (int k = 0; k < 4; k++) begin
            bx[k] = 4'd0;
            by[k] = 5'd22;
        end
    endtask

    task automatic set_blk(input int k, input int x, input int y);
        bx[k] = 4'(x);
        by[k] = 5'(y);
    endtask

    initial begin
        int pl, fl, dn, x0, x1, y0, y1;
        clear_setup();
        repeat (3) @(negedge clock);
        check("rst_row_addr", int'(row_addr), 0);
        check("rst_vga_x", int'(vga_x), 0);
        check("rst_vga_y", int'(vga_y), 0);
        check("rst_colour", int'(vga_colour), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        // Empty board, blocks in the spawn area
        run_frame(1'b1, 0, 0, 0, 1'b0, pl, fl, dn, x0, x1, y0, y1);
        check("empty_plots", pl, 3200);
        check("empty_fills", fl, 0);
        check("empty_dones", dn, 1);
        check("empty_model_fill", model_fill, 0);

        // Single cell at row 0, column 0
        board_mem[0] = 10'b0000000001;
        run_frame(1'b1, 0, 0, 0, 1'b0, pl, fl, dn, x0, x1, y0, y1);
        check("cell_fills", fl, 16);
        check("cell_model_fill", model_fill, 16);
        check("cell_xmin", x0, 60);
        check("cell_xmax", x1, 63);
        check("cell_ymin", y0, 96);
        check("cell_ymax", y1, 99);

        // Square piece in the top-right corner
        clear_setup();
        set_blk(0, 9, 19); set_blk(1, 9, 18); set_blk(2, 8, 19); set_blk(3, 8, 18);
        run_frame(1'b1, 0, 0, 0, 1'b0, pl, fl, dn, x0, x1, y0, y1);
        check("sq_fills", fl, 64);
        check("sq_xmin", x0, 92);
        check("sq_xmax", x1, 99);
        check("sq_ymin", y0, 20);
        check("sq_ymax", y1, 27);

        // Spawn-row and off-board blocks never draw; inputs change mid-frame
        clear_setup();
        set_blk(0, 2, 3); set_blk(1, 3, 20); set_blk(2, 12, 5); set_blk(3, 15, 22);
        run_frame(1'b1, 0, 50, 0, 1'b0, pl, fl, dn, x0, x1, y0, y1);
        check("snap_fills", fl, 16);
        check("snap_xmin", x0, 68);
        check("snap_xmax", x1, 71);
        check("snap_ymin", y0, 84);
        check("snap_ymax", y1, 87);

        // Second start during the frame is ignored
        clear_setup();
        run_frame(1'b1, 100, 0, 0, 1'b0, pl, fl, dn, x0, x1, y0, y1);
        check("restart_plots", pl, 3200);
        check("restart_dones", dn, 1);

        // Full row overlapped by a block, then an immediate back-to-back frame
        board_mem[5] = 10'h3FF;
        set_blk(0, 4, 5);
        for (int f = 0; f < 2; f++) begin
            run_frame(f == 0, 0, 0, 0, f == 0, pl, fl, dn, x0, x1, y0, y1);
            check("row5_fills", fl, 160);
            check("row5_plots", pl, 3200);
            check("row5_xmin", x0, 60);
            check("row5_xmax", x1, 99);
            check("row5_ymin", y0, 76);
            check("row5_ymax", y1, 79);
        end

        // Randomised boards and pieces
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 20; r++) board_mem[r] = 10'($urandom);
            for (int k = 0; k < 4; k++) set_blk(k, $urandom_range(0, 15), $urandom_range(0, 22));
            run_frame(1'b1, 0, 0, 0, 1'b0, pl, fl, dn, x0, x1, y0, y1);
            check("rand_plots", pl, 3200);
            check("rand_dones", dn, 1);
            check("rand_fills", fl, model_fill);
        end

        // Reset mid-frame: no done and no plots afterwards
        run_frame(1'b1, 0, 0, 500, 1'b0, pl, fl, dn, x0, x1, y0, y1);
        start = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        dn = 0;
        pl = 0;
        for (int c = 0; c < 3300; c++) begin
            @(negedge clock);
            if (done) dn++;
            if (plot) pl++;
        end
        check("abort_no_done", dn, 0);
        check("abort_no_plot", pl, 0);
        check("abort_idle_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
